cv32e40p_wb_arbiter: RTL and testbench
======================================

// Module: cv32e40p_wb_arbiter
// PURPOSE
//  Write-back stage arbiter downstream of the EX stage. Merges two producers
//  onto the single register-file write port B: the LSU load result and
//  X-interface (coprocessor) results. The LSU always wins arbitration.
//  X results that lose are held in a small FIFO until the port is free.
//  A starvation counter forces a drain slot by stalling EX for one cycle.
// PARAMETERS
//  X_FIFO_DEPTH   2   X-result buffer entries; power of two, >=2
//  STARVE_LIMIT   4   consecutive LSU-won cycles with FIFO non-empty before a forced drain
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous reset, active-high
//  lsu_we_i        in   1   LSU write request (EX regfile_we_wb)
//  lsu_waddr_i     in   6   LSU destination register
//  lsu_wdata_i     in   32  LSU write data
//  x_rvalid_i      in   1   X-interface result valid
//  x_rready_o      out  1   X-interface result accepted
//  x_rd_i          in   5   X destination (GPR; zero-extended to 6 bits)
//  x_data_i        in   32  X result data
//  rf_we_o         out  1   regfile port B write enable
//  rf_waddr_o      out  6   regfile port B address
//  rf_wdata_o      out  32  regfile port B data
//  wb_ready_o      out  1   to EX wb_ready_i; low during a forced-drain cycle
//  x_pending_o     out  32  one-hot OR of rd over valid FIFO entries (ID hazard check)
//  x_fifo_empty_o  out  1   FIFO holds no entries
// BEHAVIOUR
//  - Reset: FIFO empty, rd/wr pointers 0, count 0, starve counter 0, drain flag 0.
//    Outputs after reset: x_rready_o=1, wb_ready_o=1, x_pending_o=0,
//    x_fifo_empty_o=1. rf_we_o=0 unless lsu_we_i or x_rvalid_i is high.
//  - Reset asserted mid-operation discards all buffered X results. No write is issued for them.
//  - Port select is combinational, zero latency. Priority, highest first:
//    1. drain flag=1: FIFO head is written and dequeued; the LSU write is deferred.
//    2. lsu_we_i: the LSU result is written.
//    3. FIFO non-empty: the FIFO head is written and dequeued.
//    4. x_rvalid_i and FIFO empty: the X result bypasses the FIFO and is written directly.
//  - x_rready_o = ~full. Handshake occurs when x_rvalid_i & x_rready_o.
//    A handshaked result is either written by bypass (rule 4) or enqueued at wr_ptr.
//  - Full FIFO: x_rready_o=0 even if a dequeue occurs that cycle. There is no same-cycle refill.
//  - Simultaneous enqueue and dequeue: the count is unchanged and both pointers advance, mod DEPTH.
//  - x_rd_i=0: the result is accepted and consumes a slot. When it reaches the port,
//    rf_we_o=0, but it still dequeues. It contributes no bit to x_pending_o.
//  - Order: X results leave in arrival order. Bypass occurs only when the FIFO is empty.
//  - Starvation: starve_cnt increments on each cycle with lsu_we_i and FIFO non-empty
//    and drain=0. It clears to 0 on any dequeue. It saturates at STARVE_LIMIT.
//  - When starve_cnt==STARVE_LIMIT, the drain flag is set for the next cycle.
//    In that cycle: wb_ready_o=0 and the head is dequeued.
//    EX holds lsu_we/waddr/wdata stable, so the deferred LSU write lands the cycle after.
//    The drain flag clears after one cycle, and starve_cnt clears to 0.
//  - Drain flag set with the FIFO emptied meanwhile: wb_ready_o=0 for that cycle,
//    no write is issued, and the flag clears.
// TESTING
//  1. Reset, then x_rvalid_i=1, rd=5, data=0xA5A5_0001, lsu_we_i=0 ->
//     same cycle: rf_we_o=1, waddr=5, data=0xA5A5_0001, x_rready_o=1, FIFO stays empty.
//  2. lsu_we_i=1 (waddr=3, 0x11) and X (rd=7, 0x22) in the same cycle -> LSU written.
//     X enqueued, x_pending_o=0x80. Next idle cycle: rd=7 written, x_pending_o=0.
//  3. Three X results (rd 1,2,3) during continuous LSU writes -> two are accepted.
//     Third sees x_rready_o=0. After the FIFO drains they are written in order 1,2,3.
//  4. FIFO holds 1 entry while lsu_we_i is held high for 6 cycles -> after 4 cycles,
//     drain: wb_ready_o=0 for one cycle and the head is written.
//     The LSU write follows next cycle and starve_cnt returns to 0.
//  5. X rd=0 enqueued behind LSU -> x_pending_o stays 0. Its slot drains with rf_we_o=0.
//  6. rst pulsed with 2 entries buffered -> x_fifo_empty_o=1, x_pending_o=0,
//     and no X write appears after reset.

Source files
------------

// File: rtl/cv32e40p_wb_arbiter.sv
// Write-back port B arbiter: merges LSU load results and X-interface results.
// The LSU has priority; losing X results queue in a small FIFO drained under starvation control.
module cv32e40p_wb_arbiter #(
    parameter int unsigned X_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_we_i,
    input  logic [5:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        x_rvalid_i,
    output logic        x_rready_o,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_data_i,
    output logic        rf_we_o,
    output logic [5:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        wb_ready_o,
    output logic [31:0] x_pending_o,
    output logic        x_fifo_empty_o
);

    localparam int unsigned PTR_W = (X_FIFO_DEPTH > 1) ? $clog2(X_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(X_FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

    logic [4:0]              rd_mem_q   [X_FIFO_DEPTH];
    logic [4:0]              rd_mem_d   [X_FIFO_DEPTH];
    logic [31:0]             data_mem_q [X_FIFO_DEPTH];
    logic [31:0]             data_mem_d [X_FIFO_DEPTH];
    logic [X_FIFO_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [STV_W-1:0]        starve_q, starve_d;
    logic                    drain_q, drain_d;

    logic        full, empty, enq, deq, bypass;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    // Port select and handshake; the drain slot defers the LSU by one cycle.
    always_comb begin
        full       = (count_q == DEPTH_C);
        empty      = (count_q == '0);
        head_rd    = rd_mem_q[rd_ptr_q];
        head_data  = data_mem_q[rd_ptr_q];
        x_rready_o = ~full;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        deq        = 1'b0;
        bypass     = 1'b0;
        if (drain_q) begin
            if (!empty) begin
                deq        = 1'b1;
                rf_we_o    = (head_rd != 5'd0);
                rf_waddr_o = {1'b0, head_rd};
                rf_wdata_o = head_data;
            end
        end else if (lsu_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (!empty) begin
            deq        = 1'b1;
            rf_we_o    = (head_rd != 5'd0);
            rf_waddr_o = {1'b0, head_rd};
            rf_wdata_o = head_data;
        end else if (x_rvalid_i) begin
            bypass     = 1'b1;
            rf_we_o    = (x_rd_i != 5'd0);
            rf_waddr_o = {1'b0, x_rd_i};
            rf_wdata_o = x_data_i;
        end
        enq = x_rvalid_i & ~full & ~bypass;
    end

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (enq) begin
            rd_mem_d[wr_ptr_q]   = x_rd_i;
            data_mem_d[wr_ptr_q] = x_data_i;
            valid_d[wr_ptr_q]    = 1'b1;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Starvation tracking; drain_q must not re-arm from the still-saturated count.
    always_comb begin
        starve_d = starve_q;
        if (deq || drain_q) begin
            starve_d = '0;
        end else if (lsu_we_i && !empty && (starve_q != STARVE_C)) begin
            starve_d = starve_q + STV_W'(1);
        end
        drain_d = (starve_q == STARVE_C) && !drain_q;
    end

    always_comb begin
        x_pending_o = '0;
        for (int i = 0; i < X_FIFO_DEPTH; i++) begin
            if (valid_q[i] && (rd_mem_q[i] != 5'd0)) begin
                x_pending_o[rd_mem_q[i]] = 1'b1;
            end
        end
        x_fifo_empty_o = empty;
        wb_ready_o     = ~drain_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < X_FIFO_DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            valid_q    <= valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            drain_q    <= drain_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Directed bench for cv32e40p_wb_arbiter; expected regfile writes are queued and
// compared against every rf_we_o observed.
module tb_cv32e40p_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_we_i = 1'b0;
    logic [5:0]  lsu_waddr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        x_rvalid_i = 1'b0;
    logic        x_rready_o;
    logic [4:0]  x_rd_i = '0;
    logic [31:0] x_data_i = '0;
    logic        rf_we_o;
    logic [5:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        wb_ready_o;
    logic [31:0] x_pending_o;
    logic        x_fifo_empty_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    cv32e40p_wb_arbiter #(.X_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .x_rvalid_i(x_rvalid_i), .x_rready_o(x_rready_o),
        .x_rd_i(x_rd_i), .x_data_i(x_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .wb_ready_o(wb_ready_o), .x_pending_o(x_pending_o),
        .x_fifo_empty_o(x_fifo_empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Sample at the falling edge; any write must match the oldest expected write.
    task automatic at_neg();
        wr_t e;
        @(negedge clk);
        if (rf_we_o === 1'b1) begin
            chk("sb_expected_write", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_waddr", 32'(rf_waddr_o), 32'(e.addr));
                chk("sb_wdata", rf_wdata_o, e.data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lsu(input logic we, input logic [5:0] a, input logic [31:0] d);
        lsu_we_i = we; lsu_waddr_i = a; lsu_wdata_i = d;
    endtask

    task automatic set_x(input logic v, input logic [4:0] rd, input logic [31:0] d);
        x_rvalid_i = v; x_rd_i = rd; x_data_i = d;
    endtask

    initial begin
        // Reset state
        at_neg();
        chk("rst_rready", 32'(x_rready_o), 32'd1);
        chk("rst_wb_ready", 32'(wb_ready_o), 32'd1);
        chk("rst_pending", x_pending_o, 32'd0);
        chk("rst_empty", 32'(x_fifo_empty_o), 32'd1);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: bypass when idle
        set_x(1, 5'd5, 32'hA5A5_0001);
        push(6'd5, 32'hA5A5_0001);
        at_neg();
        chk("t1_rf_we", 32'(rf_we_o), 32'd1);
        chk("t1_rready", 32'(x_rready_o), 32'd1);
        tick();
        set_x(0, 5'd0, 32'd0);
        at_neg();
        chk("t1_empty", 32'(x_fifo_empty_o), 32'd1);
        tick();

        // 2: LSU wins, X queued, drained on idle cycle
        set_lsu(1, 6'd3, 32'h11);
        set_x(1, 5'd7, 32'h22);
        push(6'd3, 32'h11);
        at_neg();
        chk("t2_rready", 32'(x_rready_o), 32'd1);
        tick();
        set_lsu(0, 6'd0, 32'd0);
        set_x(0, 5'd0, 32'd0);
        push(6'd7, 32'h22);
        at_neg();
        chk("t2_pending", x_pending_o, 32'h80);
        chk("t2_empty", 32'(x_fifo_empty_o), 32'd0);
        tick();
        at_neg();
        chk("t2_pending_clr", x_pending_o, 32'd0);
        chk("t2_empty_after", 32'(x_fifo_empty_o), 32'd1);
        tick();

        // 3: FIFO fills, third X back-pressured, in-order drain
        set_lsu(1, 6'd10, 32'h100);
        set_x(1, 5'd1, 32'h1001);
        push(6'd10, 32'h100);
        at_neg();
        tick();
        set_lsu(1, 6'd11, 32'h101);
        set_x(1, 5'd2, 32'h1002);
        push(6'd11, 32'h101);
        at_neg();
        chk("t3_rready_b", 32'(x_rready_o), 32'd1);
        tick();
        set_lsu(1, 6'd12, 32'h102);
        set_x(1, 5'd3, 32'h1003);
        push(6'd12, 32'h102);
        at_neg();
        chk("t3_rready_full", 32'(x_rready_o), 32'd0);
        chk("t3_pending", x_pending_o, 32'h6);
        tick();
        set_lsu(0, 6'd0, 32'd0);
        push(6'd1, 32'h1001);
        at_neg();
        chk("t3_no_refill", 32'(x_rready_o), 32'd0);
        tick();
        push(6'd2, 32'h1002);
        at_neg();
        chk("t3_rready_free", 32'(x_rready_o), 32'd1);
        tick();
        set_x(0, 5'd0, 32'd0);
        push(6'd3, 32'h1003);
        at_neg();
        tick();
        at_neg();
        chk("t3_empty", 32'(x_fifo_empty_o), 32'd1);
        tick();

        // 4: starvation forces a drain slot
        set_lsu(1, 6'd20, 32'h200);
        set_x(1, 5'd9, 32'h99);
        push(6'd20, 32'h200);
        at_neg();
        tick();
        set_x(0, 5'd0, 32'd0);
        set_lsu(1, 6'd21, 32'h210);
        for (int c = 1; c <= 5; c++) begin
            push(6'd21, 32'h210);
            at_neg();
            chk($sformatf("t4_wb_ready_c%0d", c), 32'(wb_ready_o), 32'd1);
            chk($sformatf("t4_pending_c%0d", c), x_pending_o, 32'h200);
            tick();
        end
        push(6'd9, 32'h99);
        at_neg();
        chk("t4_drain_wb_ready", 32'(wb_ready_o), 32'd0);
        tick();
        push(6'd21, 32'h210);
        at_neg();
        chk("t4_after_wb_ready", 32'(wb_ready_o), 32'd1);
        chk("t4_after_empty", 32'(x_fifo_empty_o), 32'd1);
        tick();
        set_lsu(0, 6'd0, 32'd0);
        at_neg();
        tick();

        // 5: rd=0 consumes a slot, never writes or flags pending
        set_lsu(1, 6'd4, 32'h44);
        set_x(1, 5'd0, 32'h55);
        push(6'd4, 32'h44);
        at_neg();
        tick();
        set_lsu(0, 6'd0, 32'd0);
        set_x(0, 5'd0, 32'd0);
        at_neg();
        chk("t5_pending", x_pending_o, 32'd0);
        chk("t5_empty", 32'(x_fifo_empty_o), 32'd0);
        chk("t5_rf_we", 32'(rf_we_o), 32'd0);
        tick();
        at_neg();
        chk("t5_drained", 32'(x_fifo_empty_o), 32'd1);
        tick();

        // 7: drain flag fires after the FIFO emptied on its own
        set_lsu(1, 6'd30, 32'h300);
        set_x(1, 5'd14, 32'hE0);
        push(6'd30, 32'h300);
        at_neg();
        tick();
        set_x(0, 5'd0, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            push(6'd30, 32'h300);
            at_neg();
            tick();
        end
        set_lsu(0, 6'd0, 32'd0);
        push(6'd14, 32'hE0);
        at_neg();
        tick();
        at_neg();
        chk("t7_empty_drain_wb_ready", 32'(wb_ready_o), 32'd0);
        chk("t7_empty_drain_rf_we", 32'(rf_we_o), 32'd0);
        tick();
        at_neg();
        chk("t7_wb_ready_back", 32'(wb_ready_o), 32'd1);
        tick();

        // 6: reset discards buffered entries
        set_lsu(1, 6'd40, 32'h400);
        set_x(1, 5'd12, 32'hC0);
        push(6'd40, 32'h400);
        at_neg();
        tick();
        set_x(1, 5'd13, 32'hD0);
        push(6'd40, 32'h400);
        at_neg();
        tick();
        set_x(0, 5'd0, 32'd0);
        push(6'd40, 32'h400);
        at_neg();
        chk("t6_pending_pre", x_pending_o, 32'h3000);
        #2;
        rst = 1'b1;
        set_lsu(0, 6'd0, 32'd0);
        #1;
        chk("t6_empty_rst", 32'(x_fifo_empty_o), 32'd1);
        chk("t6_pending_rst", x_pending_o, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk($sformatf("t6_no_write_c%0d", c), 32'(rf_we_o), 32'd0);
            tick();
        end

        chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
